// File: rtl/pixel_stream_pkg.sv
// Shared types for the pixel stream source: FSM states, read-to-pixel latency
// and the per-read strobe tag that travels alongside each RAM access.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2
    } state_t;

    // Issue cycle -> RdData cycle -> PixelOut register
    localparam int PIPE_LAT = 2;

    typedef struct packed {
        logic valid;
        logic first;
        logic line;
        logic last;
    } tag_t;

endpackage

// File: rtl/stream_tag_delay.sv
// Register pipe that carries the strobe tag of each read until its pixel
// reaches the output register.
module stream_tag_delay
    import pixel_stream_pkg::*;
#(
    parameter int STAGES = PIPE_LAT
) (
    input  logic Clk,
    input  logic Reset,
    input  tag_t tag_in,
    output logic mid_valid,
    output tag_t tag_out
);

    tag_t stage [1:STAGES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 1; i <= STAGES; i++) stage[i] <= '0;
        end else begin
            stage[1] <= tag_in;
            for (int i = 2; i <= STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    // Stage before the last lines up with RdData returning from the RAM
    assign mid_valid = stage[STAGES-1].valid;
    assign tag_out   = stage[STAGES];

endmodule

// File: rtl/pixel_stream_source.sv
// Frame-memory reader: walks a Width x Height frame row-major from address 0
// and emits one pixel per cycle with Frame/Line/Done strobes aligned to it.
module pixel_stream_source
    import pixel_stream_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Width,
    input  logic [7:0]        Height,
    input  logic [7:0]        HBlank,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [7:0]        RdData,
    output logic [7:0]        PixelOut,
    output logic              FrameOut,
    output logic              LineOut,
    output logic              Busy,
    output logic              Done
);

    state_t            state, state_n;
    logic [7:0]        col, col_n;
    logic [7:0]        row, row_n;
    logic [7:0]        blank_cnt, blank_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [7:0]        width_q, width_n;
    logic [7:0]        height_q, height_n;
    logic [7:0]        hblank_q, hblank_n;
    logic              busy_n;
    logic              start_ok;
    logic              last_col, last_row;

    tag_t tag_issue, tag_out;
    logic mid_valid;

    assign start_ok = Start && !Busy && (Width != 8'd0) && (Height != 8'd0);
    assign last_col = (col == width_q - 8'd1);
    assign last_row = (row == height_q - 8'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            blank_cnt <= '0;
            addr      <= '0;
            width_q   <= '0;
            height_q  <= '0;
            hblank_q  <= '0;
            RdEn      <= 1'b0;
            Busy      <= 1'b0;
            PixelOut  <= '0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            blank_cnt <= blank_n;
            addr      <= addr_n;
            width_q   <= width_n;
            height_q  <= height_n;
            hblank_q  <= hblank_n;
            RdEn      <= (state_n == ACTIVE);
            Busy      <= busy_n;
            PixelOut  <= mid_valid ? RdData : 8'd0;
        end
    end

    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        blank_n  = blank_cnt;
        addr_n   = addr;
        width_n  = width_q;
        height_n = height_q;
        hblank_n = hblank_q;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    width_n  = Width;
                    height_n = Height;
                    hblank_n = HBlank;
                    col_n    = '0;
                    row_n    = '0;
                    addr_n   = '0;
                    state_n  = ACTIVE;
                end
            end
            ACTIVE: begin
                addr_n = addr + ADDR_W'(1);
                if (last_col) begin
                    col_n = '0;
                    if (last_row) begin
                        row_n   = '0;
                        addr_n  = '0;
                        state_n = IDLE;
                    end else begin
                        row_n = row + 8'd1;
                        if (hblank_q != 8'd0) begin
                            blank_n = hblank_q - 8'd1;
                            state_n = HBLANK;
                        end
                    end
                end else begin
                    col_n = col + 8'd1;
                end
            end
            HBLANK: begin
                if (blank_cnt == 8'd0) state_n = ACTIVE;
                else                   blank_n = blank_cnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Busy spans from the accept until the Done pixel leaves the pipe
    always_comb begin
        busy_n = Busy;
        if (state == IDLE && start_ok)         busy_n = 1'b1;
        else if (tag_out.valid && tag_out.last) busy_n = 1'b0;
    end

    always_comb begin
        tag_issue       = '0;
        tag_issue.valid = (state == ACTIVE);
        tag_issue.first = (state == ACTIVE) && (row == 8'd0) && (col == 8'd0);
        tag_issue.line  = (state == ACTIVE) && (col == 8'd0);
        tag_issue.last  = (state == ACTIVE) && last_row && last_col;
    end

    stream_tag_delay #(.STAGES(PIPE_LAT)) u_tag_delay (
        .Clk      (Clk),
        .Reset    (Reset),
        .tag_in   (tag_issue),
        .mid_valid(mid_valid),
        .tag_out  (tag_out)
    );

    assign RdAddr   = addr;
    assign FrameOut = tag_out.first;
    assign LineOut  = tag_out.line;
    assign Done     = tag_out.last;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: a frame-level model predicts RdEn, pixel,
// strobes and Busy for every cycle of each scenario window.
module tb_pixel_stream_source;

    localparam int ADDR_W = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [7:0]        Width, Height, HBlank;
    logic              RdEn;
    logic [ADDR_W-1:0] RdAddr;
    logic [7:0]        RdData;
    logic [7:0]        PixelOut;
    logic              FrameOut, LineOut, Busy, Done;

    logic [7:0]  mem [0:65535];
    logic [12:0] exp_vec [0:255];   // {RdEn, Pixel[7:0], Frame, Line, Done, Busy}
    logic [12:0] got;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (RdEn) RdData <= mem[RdAddr];

    pixel_stream_source #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Width(Width), .Height(Height), .HBlank(HBlank),
        .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
        .PixelOut(PixelOut), .FrameOut(FrameOut), .LineOut(LineOut),
        .Busy(Busy), .Done(Done)
    );

    task automatic clear_model();
        for (int i = 0; i < 256; i++) exp_vec[i] = '0;
    endtask

    // Expected behaviour of one frame whose Start is accepted in cycle s
    task automatic add_frame(input int s, input int w, input int h, input int hb);
        int len;
        int k;
        len = h * w + (h - 1) * hb;
        for (int c = s + 1; c <= s + 2 + len; c++) exp_vec[c][0] = 1'b1;
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int x = 0; x < w; x++) begin
                exp_vec[s + 1 + k][12]   = 1'b1;
                exp_vec[s + 3 + k][11:4] = mem[r * w + x];
                exp_vec[s + 3 + k][3]    = (r == 0 && x == 0);
                exp_vec[s + 3 + k][2]    = (x == 0);
                exp_vec[s + 3 + k][1]    = (r == h - 1 && x == w - 1);
                k++;
            end
            if (r < h - 1) k += hb;
        end
    endtask

    task automatic fill_ramp(input int n);
        for (int i = 0; i < n; i++) mem[i] = 8'(i + 1);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; Width = 8'd4; Height = 8'd2; HBlank = 8'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            n_checks++;
            if ({RdEn, RdAddr, PixelOut, FrameOut, LineOut, Done, Busy} !== '0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got rden=%b addr=%h pix=%h f=%b l=%b d=%b busy=%b, want all 0",
                         c, RdEn, RdAddr, PixelOut, FrameOut, LineOut, Done, Busy);
            end
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end
    endtask

    task automatic test_basic();
        fill_ramp(8);
        clear_model(); add_frame(0, 4, 2, 0);
        Width = 8'd4; Height = 8'd2; HBlank = 8'd0;
        for (int c = 0; c < 14; c++) begin
            Start = (c == 0);
            @(negedge Clk);
            got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
            n_checks++;
            if (got !== exp_vec[c]) begin
                n_fail++;
                $display("FAIL basic cyc%0d: got %h want %h", c, got, exp_vec[c]);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_hblank();
        fill_ramp(6);
        clear_model(); add_frame(0, 3, 2, 3);
        Width = 8'd3; Height = 8'd2; HBlank = 8'd3;
        for (int c = 0; c < 15; c++) begin
            Start = (c == 0);
            @(negedge Clk);
            got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
            n_checks++;
            if (got !== exp_vec[c]) begin
                n_fail++;
                $display("FAIL hblank cyc%0d: got %h want %h", c, got, exp_vec[c]);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_zero_size();
        fill_ramp(4);
        clear_model(); add_frame(6, 2, 2, 0);
        for (int c = 0; c < 16; c++) begin
            Start  = (c == 0 || c == 6);
            Width  = (c < 6) ? 8'd0 : 8'd2;
            Height = (c < 6) ? 8'd5 : 8'd2;
            HBlank = 8'd0;
            @(negedge Clk);
            got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
            n_checks++;
            if (got !== exp_vec[c]) begin
                n_fail++;
                $display("FAIL zero_size cyc%0d: got %h want %h", c, got, exp_vec[c]);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_back_to_back();
        fill_ramp(8);
        clear_model(); add_frame(0, 4, 2, 0); add_frame(11, 4, 2, 0);
        for (int c = 0; c < 26; c++) begin
            Start = (c <= 21);
            // Mid-frame size changes must not disturb the frame in flight
            Width  = (c == 0 || c == 11) ? 8'd4 : 8'(2 + (c % 3));
            Height = (c == 0 || c == 11) ? 8'd2 : 8'd7;
            HBlank = (c == 0 || c == 11) ? 8'd0 : 8'd2;
            @(negedge Clk);
            got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
            n_checks++;
            if (got !== exp_vec[c]) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, got, exp_vec[c]);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_mid_reset();
        fill_ramp(8);
        clear_model(); add_frame(0, 4, 2, 0);
        for (int c = 6; c < 256; c++) exp_vec[c] = '0;
        add_frame(7, 4, 2, 0);
        Width = 8'd4; Height = 8'd2; HBlank = 8'd0;
        for (int c = 0; c < 21; c++) begin
            Start = (c == 0 || c == 7);
            Reset = (c == 5);
            @(negedge Clk);
            got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
            n_checks++;
            if (got !== exp_vec[c]) begin
                n_fail++;
                $display("FAIL mid_reset cyc%0d: got %h want %h", c, got, exp_vec[c]);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0; Reset = 1'b0;
    endtask

    task automatic test_single_pixel();
        mem[0] = 8'hA5;
        clear_model(); add_frame(0, 1, 1, 0);
        Width = 8'd1; Height = 8'd1; HBlank = 8'd4;
        for (int c = 0; c < 7; c++) begin
            Start = (c == 0);
            @(negedge Clk);
            got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
            n_checks++;
            if (got !== exp_vec[c]) begin
                n_fail++;
                $display("FAIL single_pixel cyc%0d: got %h want %h", c, got, exp_vec[c]);
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_random();
        int w, h, hb, win;
        for (int it = 0; it < 8; it++) begin
            w  = $urandom_range(1, 6);
            h  = $urandom_range(1, 4);
            hb = $urandom_range(0, 3);
            for (int i = 0; i < w * h; i++) mem[i] = 8'($urandom);
            clear_model(); add_frame(0, w, h, hb);
            win = 6 + h * w + (h - 1) * hb;
            Width = 8'(w); Height = 8'(h); HBlank = 8'(hb);
            for (int c = 0; c < win; c++) begin
                Start = (c == 0);
                @(negedge Clk);
                got = {RdEn, PixelOut, FrameOut, LineOut, Done, Busy};
                n_checks++;
                if (got !== exp_vec[c]) begin
                    n_fail++;
                    $display("FAIL random it%0d (w%0d h%0d hb%0d) cyc%0d: got %h want %h",
                             it, w, h, hb, c, got, exp_vec[c]);
                end
                @(posedge Clk); #1;
            end
            Start = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Width = '0; Height = '0; HBlank = '0;
        test_reset();
        test_basic();
        test_hblank();
        test_zero_size();
        test_back_to_back();
        test_mid_reset();
        test_single_pixel();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_source.md
# pixel_stream_source

Frame-memory reader that generates the raw pixel stream consumed by the image-processing pipeline, including the edge stage. It reads an 8-bit greyscale frame from a synchronous single-port RAM and emits one pixel per cycle with Frame and Line strobes aligned to the pixel data. It is the transmitting end of the pixel/Frame/Line stream protocol and sits at the head of the video path.

## Interface
- ADDR_W, 16, RAM address width; must hold Width*Height-1 (255*255 fits)
- Clk  input  1  single clock, all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request one frame; sampled only while Busy=0
- Width  input  8  pixels per line, latched on Start accept
- Height  input  8  lines per frame, latched on Start accept
- HBlank  input  8  idle cycles inserted between lines, latched on Start accept
- RdEn  output  1  RAM read enable
- RdAddr  output  ADDR_W  RAM read address, row-major, frame base 0
- RdData  input  8  RAM read data, valid the cycle after RdEn/RdAddr
- PixelOut  output  8  pixel value; 0 when no pixel is present
- FrameOut  output  1  1-cycle strobe on the first pixel of a frame
- LineOut  output  1  1-cycle strobe on the first pixel of every line, including line 0
- Busy  output  1  frame in progress
- Done  output  1  1-cycle strobe on the last pixel of a frame

## Operation
- Reset: state IDLE; RdEn, RdAddr, PixelOut, FrameOut, LineOut, Busy, Done all 0; strobe pipe cleared.
- IDLE: when Start=1, Width!=0 and Height!=0, latch Width/Height/HBlank, clear col/row/address counters, enter ACTIVE, set Busy. Start with zero Width or Height is ignored.
- ACTIVE: each cycle RdEn=1 and RdAddr = running address, which then increments by 1; col increments.
  - col==Width-1 and row==Height-1: go to IDLE (Busy stays high until Done leaves the pipe).
  - col==Width-1, otherwise: row+1, col=0; go to HBLANK if HBlank!=0, else stay in ACTIVE (contiguous lines).
- HBLANK: RdEn=0, count HBlank cycles, then return to ACTIVE. RdAddr holds its value.
- Strobe tags generated alongside each read: first (row 0, col 0), line (col 0), last (last row, last col), valid. They are delayed two stages so they align with RdData registered into PixelOut.
- Cycles without a valid read produce PixelOut=0 and all strobes 0.
- Start while Busy=1 is ignored. Width/Height/HBlank changes mid-frame have no effect.
- Downstream filters that index the previous line by Width require HBlank=0.
- Reset mid-frame: the frame is abandoned. Outputs are all 0 from the next cycle, with no partial Done.

## Timing
- Start high in cycle 0 (Busy=0) -> RdAddr=0 in cycle 1 -> RdData in cycle 2 -> PixelOut/FrameOut/LineOut in cycle 3. Latency is 3 cycles from the Start cycle to the first pixel.
- Busy is 1 from cycle 1 through the Done cycle inclusive, and 0 the cycle after.
- Frame length on output: Height*Width + (Height-1)*HBlank cycles.
- Done coincides with the last pixel. For Width=Height=1, FrameOut, LineOut and Done are all high in the same cycle.
- Earliest next Start is the cycle after Done. Start held high therefore gives a 3-cycle gap between frames.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- pixel_stream_pkg holds the state enum (IDLE, ACTIVE, HBLANK), PIPE_LAT=2, and the strobe-tag struct (valid, first, line, last).
- One sub-module: stream_tag_delay, a PIPE_LAT-stage register pipe for the tag struct, cleared by Reset.
- The top level holds the FSM, the col/row/blank counters, the address counter and the output register.

## Test plan
- Width=4, Height=2, HBlank=0, RAM[i]=i+1, Start in cycle 0 -> PixelOut 1..8 in cycles 3..10; FrameOut in cycle 3 only; LineOut in cycles 3 and 7; Done in cycle 10; Busy high in cycles 1..10.
- Width=3, Height=2, HBlank=3, RAM[i]=i+1 -> pixels 1,2,3 in cycles 3..5; PixelOut=0 and no strobes in cycles 6..8; pixels 4,5,6 in cycles 9..11; LineOut in cycles 3 and 9; Done in cycle 11.
- Width=0, Height=5, Start pulsed -> Busy, RdEn and all strobes stay 0; a following valid Start is accepted normally.
- Start held high, Width=4, Height=2 -> first frame as in test 1; Start in cycles 1..10 ignored; second frame accepted in cycle 11 with FrameOut in cycle 14.
- Test 1 with Reset high in cycle 5 -> from cycle 6 all outputs 0 and no Done; Start in cycle 7 -> FrameOut in cycle 10 with PixelOut=1.
- Width=1, Height=1, RAM[0]=0xA5 -> cycle 3: PixelOut=0xA5 with FrameOut=LineOut=Done=1; Busy low from cycle 4.
